decoder_mul_share_arb: RTL

Round-robin arbiter and 2-stage pipeline that shares one 16-bit-signed × 9-bit-unsigned multiplier among `N_REQ` decoder requesters (e.g. parallel dense-layer neuron lanes). Each requester presents an operand pair over a valid/ready handshake. The block grants one requester per cycle and drives the shared multiplier from registered operands. It returns the 25-bit signed product to the originating requester over a per-requester valid/ready response channel with backpressure.

---
 rtl/decoder_mul_pkg.sv | 20 ++
 rtl/decoder_mul_16s_9ns_25_1_1.sv | 20 ++
 rtl/decoder_rr_arbiter.sv | 66 ++++++
 rtl/decoder_mul_share_arb.sv | 109 ++++++++++
 4 files changed

// File: rtl/decoder_mul_pkg.sv
// Shared types and widths for the shared-multiplier decoder slice.
// Contents: operand/product widths, requester id type sized for the largest
// supported requester count, and the stage-1 payload struct.
package decoder_mul_pkg;

  localparam int A_W       = 16;          // operand A, signed
  localparam int B_W       = 9;           // operand B, unsigned
  localparam int P_W       = A_W + B_W;   // exact signed product
  localparam int N_REQ_MAX = 8;
  localparam int ID_W      = $clog2(N_REQ_MAX);

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic signed [A_W-1:0] a;
    logic [B_W-1:0]        b;
    id_t                   id;
  } s1_t;

endpackage

// File: rtl/decoder_mul_16s_9ns_25_1_1.sv
// Combinational 16-bit signed x 9-bit unsigned multiplier, 25-bit signed result.
// Ports:
//   din0 : 16-bit signed operand
//   din1 : 9-bit unsigned operand
//   dout : 25-bit signed product (exact, cannot overflow)
module decoder_mul_16s_9ns_25_1_1 (
  input  logic [15:0] din0,
  input  logic [8:0]  din1,
  output logic [24:0] dout
);

  logic signed [24:0] a_ext;
  logic signed [24:0] b_ext;

  // B gets a zero sign bit so the signed multiply treats it as unsigned.
  assign a_ext = 25'($signed(din0));
  assign b_ext = 25'($signed({1'b0, din1}));
  assign dout  = a_ext * b_ext;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter over N_REQ requesters.
// Ports:
//   ap_clk, ap_rst : clock, synchronous active-high reset
//   req            : request vector
//   advance        : a grant was consumed this cycle; rotate the pointer
//   grant          : one-hot grant (all zero when no request)
//   grant_id       : index of the granted requester
module decoder_rr_arbiter
  import decoder_mul_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output id_t              grant_id
);

  localparam int SW = ID_W + 1;

  id_t                ptr_reg;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               found;
  id_t                offset;
  logic [SW-1:0]      sum;

  // Rotate so the current priority holder sits at bit 0; the first set bit
  // of the rotated vector is then the offset from ptr of the winner.
  assign req_dbl = {req, req};
  assign req_rot = N_REQ'(req_dbl >> ptr_reg);

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = id_t'(k);
      end
    end
    sum = {1'b0, ptr_reg} + {1'b0, offset};
    if (sum >= SW'(N_REQ)) begin
      sum = sum - SW'(N_REQ);
    end
    grant_id = sum[ID_W-1:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant[gi] = found && (grant_id == id_t'(gi));
    end
  endgenerate

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= (grant_id == id_t'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_mul_share_arb.sv
// Shares one 16s x 9u multiplier among N_REQ requesters through a round-robin
// arbiter and a 2-stage pipeline (S1 operands, S2 product) with backpressure.
// Ports:
//   ap_clk, ap_rst : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester operand handshake (ready one-hot)
//   req_a, req_b        : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : per-requester product handshake (valid one-hot)
//   rsp_p               : shared product bus for the requester flagged in rsp_valid
module decoder_mul_share_arb
  import decoder_mul_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [P_W-1:0]       rsp_p
);

  logic [N_REQ-1:0] grant;
  id_t              grant_id;

  s1_t              s1_reg;
  s1_t              s1_next;
  logic             s1_vld_reg;
  logic [P_W-1:0]   s2_p_reg;
  id_t              s2_id_reg;
  logic             s2_vld_reg;

  logic [P_W-1:0]   mul_p;
  logic [N_REQ-1:0] s2_sel;
  logic             s2_free;
  logic             s1_free;
  logic             accept;

  decoder_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .req      (req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // One-hot destination of the product currently held in S2.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_sel
      assign s2_sel[gi] = s2_vld_reg && (s2_id_reg == id_t'(gi));
    end
  endgenerate

  assign s2_free   = !s2_vld_reg || |(s2_sel & rsp_ready);
  assign s1_free   = !s1_vld_reg || s2_free;
  // Nothing is accepted during the reset cycle, so no request is lost to it.
  assign req_ready = (ap_rst || !s1_free) ? '0 : grant;
  assign accept    = |req_ready;
  assign rsp_valid = s2_sel;
  assign rsp_p     = s2_p_reg;

  always_comb begin
    s1_next    = '0;
    s1_next.id = grant_id;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        s1_next.a = req_a[i*A_W +: A_W];
        s1_next.b = req_b[i*B_W +: B_W];
      end
    end
  end

  decoder_mul_16s_9ns_25_1_1 u_mul (
    .din0 (s1_reg.a),
    .din1 (s1_reg.b),
    .dout (mul_p)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_vld_reg <= 1'b0;
      s1_reg     <= '0;
      s2_vld_reg <= 1'b0;
      s2_p_reg   <= '0;
      s2_id_reg  <= '0;
    end else begin
      // S1 refills whenever it is empty or draining into S2.
      if (s1_free) begin
        s1_vld_reg <= accept;
        if (accept) begin
          s1_reg <= s1_next;
        end
      end
      // S2 takes S1 whenever its own content leaves (or it was empty).
      if (s2_free) begin
        s2_vld_reg <= s1_vld_reg;
        if (s1_vld_reg) begin
          s2_p_reg  <= mul_p;
          s2_id_reg <= s1_reg.id;
        end
      end
    end
  end

endmodule
